// File: rtl/scale_stretch.sv
// Per-channel pulse stretcher for stochastic bitstreams: each input 1 can hold its
// output high for LEN more cycles, using retrigger, one-shot or accumulate counting, or bypass.
module scale_stretch #(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          EN,
    input  logic [1:0]    MODE,
    input  logic [CW-1:0] LEN,
    input  logic [N-1:0]  IN,
    output logic [N-1:0]  OUT,
    output logic [N-1:0]  BUSY
);

    localparam logic [1:0] MODE_RETRIG = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_ACCUM = 2'd2;
    localparam logic [CW:0] SAT = {1'b0, {CW{1'b1}}};

    logic [CW-1:0] cnt     [N];
    logic [CW-1:0] cnt_nxt [N];
    logic [N-1:0]  out_nxt;
    logic [CW-1:0] dec;
    logic [CW:0]   acc;

    always_comb begin
        for (int n = 0; n < N; n++) begin
            BUSY[n] = (cnt[n] != '0);
        end
    end

    always_comb begin
        out_nxt = '0;
        dec     = '0;
        acc     = '0;
        for (int n = 0; n < N; n++) begin
            cnt_nxt[n] = cnt[n];
            dec        = BUSY[n] ? cnt[n] - 1'b1 : cnt[n];
            acc        = '0;
            if (EN) begin
                out_nxt[n] = IN[n] | BUSY[n];
                case (MODE)
                    MODE_RETRIG:  cnt_nxt[n] = IN[n] ? LEN : dec;
                    MODE_ONESHOT: cnt_nxt[n] = (IN[n] && !BUSY[n]) ? LEN : dec;
                    MODE_ACCUM: begin
                        // widened so a large LEN on a nearly-full counter saturates instead of wrapping
                        acc = {1'b0, dec} + (IN[n] ? {1'b0, LEN} : '0);
                        cnt_nxt[n] = (acc > SAT) ? {CW{1'b1}} : acc[CW-1:0];
                    end
                    default: begin
                        out_nxt[n] = IN[n];
                        cnt_nxt[n] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT <= '0;
            for (int n = 0; n < N; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            OUT <= out_nxt;
            for (int n = 0; n < N; n++) begin
                cnt[n] <= cnt_nxt[n];
            end
        end
    end

endmodule

// File: tb/tb_scale_stretch.sv
// Directed and random checks of scale_stretch against a per-channel reference model,
// with expected OUT/BUSY pushed to a queue when stimulus is applied.
module tb_scale_stretch;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK;
    logic          RST_N;
    logic          EN;
    logic [1:0]    MODE;
    logic [CW-1:0] LEN;
    logic [N-1:0]  IN;
    logic [N-1:0]  OUT;
    logic [N-1:0]  BUSY;

    scale_stretch #(.N(N), .CW(CW)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .EN   (EN),
        .MODE (MODE),
        .LEN  (LEN),
        .IN   (IN),
        .OUT  (OUT),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    int           m_cnt [N];
    logic [N-1:0] m_out;
    logic [2*N-1:0] exp_q [$];

    function automatic logic [N-1:0] m_busy();
        logic [N-1:0] b;
        for (int c = 0; c < N; c++) b[c] = (m_cnt[c] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) m_cnt[c] = 0;
        m_out = '0;
    endtask

    task automatic model_edge(input logic en, input logic [1:0] mode,
                              input logic [CW-1:0] len, input logic [N-1:0] inv);
        for (int c = 0; c < N; c++) begin
            int cur;
            int s;
            cur = m_cnt[c];
            if (!en) begin
                m_out[c] = 1'b0;
            end else if (mode == 2'd3) begin
                m_out[c] = inv[c];
                m_cnt[c] = 0;
            end else begin
                m_out[c] = inv[c] || (cur > 0);
                if (mode == 2'd0) begin
                    m_cnt[c] = inv[c] ? int'(len) : ((cur > 0) ? cur - 1 : 0);
                end else if (mode == 2'd1) begin
                    m_cnt[c] = (inv[c] && cur == 0) ? int'(len) : ((cur > 0) ? cur - 1 : 0);
                end else begin
                    s = cur - ((cur > 0) ? 1 : 0) + (inv[c] ? int'(len) : 0);
                    m_cnt[c] = (s > CMAX) ? CMAX : s;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic [1:0] mode, input logic [CW-1:0] len,
                        input logic [N-1:0] inv, output logic [N-1:0] o);
        logic [2*N-1:0] e;
        @(negedge CLK);
        EN = en; MODE = mode; LEN = len; IN = inv;
        model_edge(en, mode, len, inv);
        exp_q.push_back({m_out, m_busy()});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk("out", 32'(OUT), 32'(e[2*N-1:N]));
        chk("busy", 32'(BUSY), 32'(e[N-1:0]));
        o = OUT;
    endtask

    logic [N-1:0] o;
    int hc;
    int hb;
    logic [N-1:0] pat [9];

    initial begin
        RST_N = 1'b1; EN = 1'b0; MODE = '0; LEN = '0; IN = '0;
        model_reset();
        #1 RST_N = 1'b0;
        #11;
        chk("reset_out", 32'(OUT), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // retrigger, LEN=3, single pulse on channel 0
        hc = 0; hb = 0;
        step(1'b1, 2'd0, 4'd3, 4'b0001, o); hc += int'(o[0]); hb += int'(BUSY[0]);
        repeat (5) begin
            step(1'b1, 2'd0, 4'd3, 4'b0000, o); hc += int'(o[0]); hb += int'(BUSY[0]);
        end
        chk("pulse_len3_out_cycles", 32'(hc), 32'd4);
        chk("pulse_len3_busy_cycles", 32'(hb), 32'd3);

        // retrigger vs one-shot with pulses two cycles apart on channel 1
        pat = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int m = 0; m < 2; m++) begin
            hc = 0;
            for (int k = 0; k < 9; k++) begin
                step(1'b1, 2'(m), 4'd4, pat[k], o); hc += int'(o[1]);
            end
            chk(m == 0 ? "retrig_cycles" : "oneshot_cycles", 32'(hc), (m == 0) ? 32'd7 : 32'd5);
        end

        // accumulate: 14 then +5 saturates at 15
        step(1'b1, 2'd2, 4'd14, 4'b0100, o);
        step(1'b1, 2'd2, 4'd5, 4'b0100, o);
        hc = int'(o[2]);
        repeat (18) begin
            step(1'b1, 2'd2, 4'd5, 4'b0000, o); hc += int'(o[2]);
        end
        chk("accum_sat_cycles", 32'(hc), 32'd16);

        // LEN changes after the load must not stretch a running count
        hc = 0;
        step(1'b1, 2'd0, 4'd3, 4'b0001, o); hc += int'(o[0]);
        repeat (6) begin
            step(1'b1, 2'd0, 4'd7, 4'b0000, o); hc += int'(o[0]);
        end
        chk("len_change_cycles", 32'(hc), 32'd4);

        // mode changes preserve the count; entering bypass clears it
        step(1'b1, 2'd0, 4'd6, 4'b1000, o);
        step(1'b1, 2'd0, 4'd6, 4'b0000, o);
        step(1'b1, 2'd2, 4'd6, 4'b0000, o);
        step(1'b1, 2'd2, 4'd6, 4'b1000, o);
        step(1'b1, 2'd1, 4'd6, 4'b0000, o);
        step(1'b1, 2'd3, 4'd6, 4'b0000, o);
        chk("bypass_clears_busy", 32'(BUSY), 32'd0);
        step(1'b1, 2'd0, 4'd6, 4'b0000, o);
        chk("after_bypass_out", 32'(o), 32'd0);

        // bypass with random input
        repeat (20) step(1'b1, 2'd3, 4'($urandom), 4'($urandom), o);

        // LEN=0 reduces to a registered copy
        repeat (8) step(1'b1, 2'($urandom_range(0, 2)), 4'd0, 4'($urandom), o);

        // EN freeze mid-stretch at cnt=2
        hc = 0;
        step(1'b1, 2'd0, 4'd3, 4'b0001, o);
        step(1'b1, 2'd0, 4'd3, 4'b0000, o);
        repeat (5) begin
            step(1'b0, 2'd0, 4'd3, 4'($urandom), o); hc += int'(o[0]);
        end
        chk("en_low_out_cycles", 32'(hc), 32'd0);
        hc = 0;
        repeat (4) begin
            step(1'b1, 2'd0, 4'd3, 4'b0000, o); hc += int'(o[0]);
        end
        chk("en_resume_cycles", 32'(hc), 32'd2);

        // async reset mid-stretch
        step(1'b1, 2'd0, 4'd8, 4'b0001, o);
        step(1'b1, 2'd0, 4'd8, 4'b0000, o);
        #2 RST_N = 1'b0;
        model_reset();
        #1;
        chk("async_rst_out", 32'(OUT), 32'd0);
        chk("async_rst_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        #1 RST_N = 1'b1;
        hc = 0;
        repeat (10) begin
            step(1'b1, 2'd0, 4'd8, 4'b0000, o); hc += int'(o[0]);
        end
        chk("post_rst_out_cycles", 32'(hc), 32'd0);

        // random soak
        repeat (200) begin
            step(($urandom_range(0, 7) != 0), 2'($urandom), 4'($urandom),
                 4'($urandom & $urandom), o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
